title_logo_compositor: RTL
==========================

// Module: title_logo_compositor
// PURPOSE
//  Downstream pixel stage for the logo display: merges logo rgb/on with the sprite and background layers into the final VGA rgb.
//  Delays video_on/hsync/vsync by ROM_LAT clocks so they line up with the synchronous-ROM pixel data.
//  Runs the title-screen sequencer (fade-in, hold, blink, play), which gates the logo layer and flags game start.
// PARAMETERS
//  ROM_LAT          1    clk latency of logo/sprite/bg ROM data relative to x/y; sync delay depth (1..4)
//  FADE_STEP_FRAMES 4    frames per fade level increment
//  HOLD_FRAMES      120  frames logo held at full level before blinking
//  BLINK_HALF       30   frames per blink half-period (logo on, then logo off)
// PORTS
//  clk            in   1   system clock
//  reset          in   1   asynchronous, active-high reset
//  video_on       in   1   from vga_sync, aligned with x/y
//  hsync, vsync   in   1   from vga_sync, aligned with x/y; vsync is an active-high pulse
//  logo_rgb       in   12  game logo ROM colour, ROM_LAT late
//  logo_on        in   1   logo pixel opaque, ROM_LAT late
//  sprite_rgb     in   12  sprite layer colour, ROM_LAT late
//  sprite_on      in   1   sprite pixel opaque, ROM_LAT late
//  bg_rgb         in   12  background colour, ROM_LAT late
//  start          in   1   start button, already debounced, level
//  game_over      in   1   one-clk pulse from game logic
//  rgb_out        out  12  final pixel colour, registered
//  hsync_out      out  1   hsync delayed ROM_LAT+1 clks
//  vsync_out      out  1   vsync delayed ROM_LAT+1 clks
//  game_active    out  1   high in PLAY state
// BEHAVIOUR
//  Reset: rgb_out=0, hsync_out=0, vsync_out=0, game_active=0, state=FADE, level=0, all counters=0, sync pipes=0.
//  Sync path: video_on/hsync/vsync pass through a ROM_LAT-deep shift register, then the output register. Sync latency = ROM_LAT+1 clks.
//  Colour path: one output register. Colour latency = 1 clk after the aligned ROM data.
//  Frame tick: 1-clk pulse on each rising edge of raw vsync (previous vsync=0, current=1). All frame counters advance only on this tick.
//  Pixel mux, registered, using the delayed video_on:
//    video_on=0 -> 0
//    else sprite_on -> sprite_rgb
//    else logo_on & logo_vis -> logo_scaled
//    else -> bg_rgb
//  logo_scaled, per 4-bit channel c: (c*level)>>4 with level 0..16. Uses a 9-bit product truncated to 4 bits. level=16 gives c exactly; level=0 gives 0.
//  logo_vis: 1 in FADE and HOLD, 1 during the blink-on phase, 0 during the blink-off phase and in PLAY.
//  FSM, transitions on clk:
//   FADE:  level += 1 every FADE_STEP_FRAMES ticks. When level reaches 16 -> HOLD, frame counter cleared. start is ignored in FADE.
//   HOLD:  after HOLD_FRAMES ticks -> BLINK with phase=on. start press -> PLAY.
//   BLINK: phase toggles every BLINK_HALF ticks. start press -> PLAY.
//   PLAY:  game_active=1. game_over -> FADE with level=0 and counters cleared.
//  start press = rising edge of start (registered). A start held high across entry to HOLD does not count as a press.
//  Simultaneous events:
//    start press and frame tick in the same clk: the transition wins and the counter is cleared.
//    game_over outside PLAY: ignored.
//  Frame counter width = clog2(max(HOLD_FRAMES, BLINK_HALF, FADE_STEP_FRAMES))+1. It never wraps because it is cleared on every state change.
//  Reset mid-frame: outputs go to 0 asynchronously. The first frame tick after release needs a full 0->1 vsync edge.
// TESTING
//  1. ROM_LAT=1: single-clk pulses on hsync and vsync -> hsync_out/vsync_out pulse exactly 2 clks later, same width.
//  2. Pixel mux:
//     sprite_on=1, logo_on=1, sprite_rgb=12'hF00 -> rgb_out=12'hF00 one clk later
//     sprite_on=0, level=16, logo_rgb=12'h6A4 -> rgb_out=12'h6A4
//     video_on=0 -> rgb_out=0
//  3. Fade scaling: FADE_STEP_FRAMES=1, logo_rgb=12'hFFF. After 8 vsync edges -> level=8, rgb_out=12'h777. After 16 edges -> state HOLD, rgb_out=12'hFFF.
//  4. Hold and blink: HOLD_FRAMES=3, BLINK_HALF=2.
//     After 3 ticks in HOLD -> BLINK. Logo shown 2 frames, replaced by bg_rgb 2 frames, then repeats.
//  5. Start handling:
//     start held high through FADE into HOLD -> stays HOLD
//     release, then press -> PLAY next clk, game_active=1, logo suppressed
//     game_over pulse -> FADE, level=0, game_active=0
//  6. Reset asserted mid-BLINK with vsync high -> all outputs 0 immediately. After release, no tick until vsync falls then rises; fade restarts from level 0.

Source files
------------

// File: rtl/title_logo_compositor.sv
// title_logo_compositor
// Final pixel stage for the logo display. Merges the sprite, logo and
// background layers into the VGA colour. It also delays the sync signals so
// they line up with the synchronous-ROM pixel data, and runs the title-screen
// sequencer (fade-in, hold, blink, play). The sequencer gates the logo layer
// and flags game start.
//
// Ports
//   clk, reset            system clock, asynchronous active-high reset
//   video_on/hsync/vsync  raw timing from vga_sync, aligned with x/y
//   logo_rgb/logo_on      logo ROM colour/opacity, ROM_LAT clocks late
//   sprite_rgb/sprite_on  sprite layer colour/opacity, ROM_LAT clocks late
//   bg_rgb                background colour, ROM_LAT clocks late
//   start                 debounced start button (level)
//   game_over             one-clock pulse from game logic
//   rgb_out               registered final pixel colour
//   hsync_out/vsync_out   syncs delayed ROM_LAT+1 clocks
//   game_active           high in PLAY
//
// state | meaning
// FADE  | logo level ramps 0..16, one step every FADE_STEP_FRAMES frames
// HOLD  | logo at full level for HOLD_FRAMES frames
// BLINK | logo alternates on/off every BLINK_HALF frames
// PLAY  | game running, logo hidden
module title_logo_compositor #(
    parameter int ROM_LAT          = 1,
    parameter int FADE_STEP_FRAMES = 4,
    parameter int HOLD_FRAMES      = 120,
    parameter int BLINK_HALF       = 30
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        video_on,
    input  logic        hsync,
    input  logic        vsync,
    input  logic [11:0] logo_rgb,
    input  logic        logo_on,
    input  logic [11:0] sprite_rgb,
    input  logic        sprite_on,
    input  logic [11:0] bg_rgb,
    input  logic        start,
    input  logic        game_over,
    output logic [11:0] rgb_out,
    output logic        hsync_out,
    output logic        vsync_out,
    output logic        game_active
);

    localparam int MAX_A      = (HOLD_FRAMES > BLINK_HALF) ? HOLD_FRAMES : BLINK_HALF;
    localparam int MAX_FRAMES = (MAX_A > FADE_STEP_FRAMES) ? MAX_A : FADE_STEP_FRAMES;
    localparam int CNT_W      = $clog2(MAX_FRAMES) + 1;

    localparam logic [CNT_W-1:0] FADE_TC  = CNT_W'(FADE_STEP_FRAMES - 1);
    localparam logic [CNT_W-1:0] HOLD_TC  = CNT_W'(HOLD_FRAMES - 1);
    localparam logic [CNT_W-1:0] BLINK_TC = CNT_W'(BLINK_HALF - 1);

    typedef enum logic [1:0] {FADE, HOLD, BLINK, PLAY} state_t;

    state_t            state, state_n;
    logic [4:0]        level, level_n;
    logic [CNT_W-1:0]  frame_cnt, frame_cnt_n;
    logic              phase, phase_n;

    logic [ROM_LAT-1:0] von_pipe, hs_pipe, vs_pipe;
    logic               vsync_prev, start_prev;
    logic               tick, press, logo_vis;
    logic [11:0]        logo_scaled;

    // Sync pipes and edge-detect history.
    // vsync_prev resets to 1 so a vsync that is already high at reset release
    // cannot produce a tick; the first tick needs a full 0->1 edge.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            von_pipe   <= '0;
            hs_pipe    <= '0;
            vs_pipe    <= '0;
            vsync_prev <= 1'b1;
            start_prev <= 1'b0;
        end else begin
            von_pipe[0] <= video_on;
            hs_pipe[0]  <= hsync;
            vs_pipe[0]  <= vsync;
            for (int i = 1; i < ROM_LAT; i++) begin
                von_pipe[i] <= von_pipe[i-1];
                hs_pipe[i]  <= hs_pipe[i-1];
                vs_pipe[i]  <= vs_pipe[i-1];
            end
            vsync_prev <= vsync;
            start_prev <= start;
        end
    end

    assign tick  = vsync & ~vsync_prev;
    // start_prev tracks start in every state, so a level held across entry
    // into HOLD has no edge left to count.
    assign press = start & ~start_prev;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state     <= FADE;
            level     <= '0;
            frame_cnt <= '0;
            phase     <= 1'b0;
        end else begin
            state     <= state_n;
            level     <= level_n;
            frame_cnt <= frame_cnt_n;
            phase     <= phase_n;
        end
    end

    always_comb begin
        state_n     = state;
        level_n     = level;
        frame_cnt_n = frame_cnt;
        phase_n     = phase;
        case (state)
            FADE: begin
                if (tick) begin
                    if (frame_cnt == FADE_TC) begin
                        frame_cnt_n = '0;
                        level_n     = level + 5'd1;
                        if (level == 5'd15) state_n = HOLD;
                    end else begin
                        frame_cnt_n = frame_cnt + CNT_W'(1);
                    end
                end
            end
            HOLD: begin
                if (press) begin
                    state_n     = PLAY;
                    frame_cnt_n = '0;
                end else if (tick) begin
                    if (frame_cnt == HOLD_TC) begin
                        state_n     = BLINK;
                        phase_n     = 1'b1;
                        frame_cnt_n = '0;
                    end else begin
                        frame_cnt_n = frame_cnt + CNT_W'(1);
                    end
                end
            end
            BLINK: begin
                if (press) begin
                    state_n     = PLAY;
                    phase_n     = 1'b0;
                    frame_cnt_n = '0;
                end else if (tick) begin
                    if (frame_cnt == BLINK_TC) begin
                        phase_n     = ~phase;
                        frame_cnt_n = '0;
                    end else begin
                        frame_cnt_n = frame_cnt + CNT_W'(1);
                    end
                end
            end
            PLAY: begin
                if (game_over) begin
                    state_n     = FADE;
                    level_n     = '0;
                    frame_cnt_n = '0;
                    phase_n     = 1'b0;
                end
            end
            default: state_n = FADE;
        endcase
    end

    // (c * level) >> 4 with level 0..16; the 9-bit product never exceeds 240.
    function automatic logic [3:0] scale(input logic [3:0] c, input logic [4:0] lv);
        logic [8:0] p;
        p = {5'd0, c} * {4'd0, lv};
        return 4'(p >> 4);
    endfunction

    assign logo_scaled = {scale(logo_rgb[11:8], level),
                          scale(logo_rgb[7:4],  level),
                          scale(logo_rgb[3:0],  level)};

    assign logo_vis    = (state == FADE) || (state == HOLD) || ((state == BLINK) && phase);
    assign game_active = (state == PLAY);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rgb_out   <= '0;
            hsync_out <= 1'b0;
            vsync_out <= 1'b0;
        end else begin
            hsync_out <= hs_pipe[ROM_LAT-1];
            vsync_out <= vs_pipe[ROM_LAT-1];
            if (!von_pipe[ROM_LAT-1])     rgb_out <= '0;
            else if (sprite_on)           rgb_out <= sprite_rgb;
            else if (logo_on && logo_vis) rgb_out <= logo_scaled;
            else                          rgb_out <= bg_rgb;
        end
    end

endmodule
